keypad_code_lock: RTL and testbench

//  Parametrised successor to the 3-digit keypad lock. Decodes 16-bit one-hot keypad codes into a DIGITS-long BCD

---
 rtl/keypad_code_lock_pkg.sv | 69 ++++++
 rtl/keypad_code_lock_buzzer_tone.sv | 89 ++++++++
 rtl/keypad_code_lock.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_code_lock_pkg.sv
// Shared types and constants for the keypad code lock: state/tone encodings,
// keypad code map and the one-hot key decoder.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_PASS    = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    TONE_KEY = 2'd0,
    TONE_OK  = 2'd1,
    TONE_ERR = 2'd2
  } tone_sel_e;

  localparam logic [15:0] KEY_0     = 16'h0008;
  localparam logic [15:0] KEY_1     = 16'h0080;
  localparam logic [15:0] KEY_2     = 16'h0040;
  localparam logic [15:0] KEY_3     = 16'h0020;
  localparam logic [15:0] KEY_4     = 16'h0800;
  localparam logic [15:0] KEY_5     = 16'h0400;
  localparam logic [15:0] KEY_6     = 16'h0200;
  localparam logic [15:0] KEY_7     = 16'h8000;
  localparam logic [15:0] KEY_8     = 16'h4000;
  localparam logic [15:0] KEY_9     = 16'h2000;
  localparam logic [15:0] KEY_ENTER = 16'h0001;
  localparam logic [15:0] KEY_CLEAR = 16'h1000;
  localparam logic [15:0] KEY_ADMIN = 16'h0100;

  localparam logic [3:0] BLANK      = 4'hF;
  localparam logic [3:0] PASS_GLYPH = 4'hA;
  localparam logic [3:0] LOCK_GLYPH = 4'h0;

  typedef struct packed {
    logic       valid;
    logic       is_digit;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic       admin;
  } key_t;

  // Anything other than exactly one mapped code (multi-hot, unmapped, none) decodes as invalid.
  function automatic key_t decode_key(input logic [15:0] code);
    key_t k;
    k          = '0;
    k.valid    = 1'b1;
    k.is_digit = 1'b1;
    case (code)
      KEY_0: k.digit = 4'd0;
      KEY_1: k.digit = 4'd1;
      KEY_2: k.digit = 4'd2;
      KEY_3: k.digit = 4'd3;
      KEY_4: k.digit = 4'd4;
      KEY_5: k.digit = 4'd5;
      KEY_6: k.digit = 4'd6;
      KEY_7: k.digit = 4'd7;
      KEY_8: k.digit = 4'd8;
      KEY_9: k.digit = 4'd9;
      KEY_ENTER: begin k.is_digit = 1'b0; k.enter = 1'b1; end
      KEY_CLEAR: begin k.is_digit = 1'b0; k.clear = 1'b1; end
      KEY_ADMIN: begin k.is_digit = 1'b0; k.admin = 1'b1; end
      default: begin k.valid = 1'b0; k.is_digit = 1'b0; end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_code_lock_buzzer_tone.sv
// Buzzer tone generator: one active tone at a time, restarted by every request.
// The error tone is silenced during the middle third of its duration.
module buzzer_tone
  import lock_pkg::*;
#(
  parameter int KEY_DIV = 50000,
  parameter int OK_DIV  = 25000,
  parameter int ERR_DIV = 100000,
  parameter int KEY_CYC = 10000000,
  parameter int OK_CYC  = 30000000,
  parameter int ERR_CYC = 15000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] sel,
  output logic       buzzer
);

  localparam int MAX_CYC = (KEY_CYC > OK_CYC) ? ((KEY_CYC > ERR_CYC) ? KEY_CYC : ERR_CYC)
                                              : ((OK_CYC > ERR_CYC) ? OK_CYC : ERR_CYC);
  localparam int MAX_DIV = (KEY_DIV > OK_DIV) ? ((KEY_DIV > ERR_DIV) ? KEY_DIV : ERR_DIV)
                                              : ((OK_DIV > ERR_DIV) ? OK_DIV : ERR_DIV);
  localparam int DW = $clog2(MAX_CYC + 1);
  localparam int HW = $clog2(MAX_DIV + 1);

  localparam logic [DW-1:0] ERR_LO = DW'(ERR_CYC / 3);
  localparam logic [DW-1:0] ERR_HI = DW'((2 * ERR_CYC) / 3);

  logic          r_active;
  logic [1:0]    r_sel;
  logic [DW-1:0] r_dur;
  logic [HW-1:0] r_half;
  logic          r_tone;
  logic [DW-1:0] w_last_cyc;
  logic [HW-1:0] w_last_div;
  logic          w_gate;

  always_comb begin
    w_last_cyc = DW'(KEY_CYC - 1);
    w_last_div = HW'(KEY_DIV - 1);
    case (r_sel)
      TONE_OK: begin
        w_last_cyc = DW'(OK_CYC - 1);
        w_last_div = HW'(OK_DIV - 1);
      end
      TONE_ERR: begin
        w_last_cyc = DW'(ERR_CYC - 1);
        w_last_div = HW'(ERR_DIV - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_sel    <= TONE_KEY;
      r_dur    <= '0;
      r_half   <= '0;
      r_tone   <= 1'b0;
    end else if (req) begin
      r_active <= 1'b1;
      r_sel    <= sel;
      r_dur    <= '0;
      r_half   <= '0;
      r_tone   <= 1'b1;
    end else if (r_active) begin
      if (r_dur == w_last_cyc) begin
        r_active <= 1'b0;
        r_dur    <= '0;
        r_half   <= '0;
        r_tone   <= 1'b0;
      end else begin
        r_dur <= r_dur + DW'(1);
        if (r_half == w_last_div) begin
          r_half <= '0;
          r_tone <= ~r_tone;
        end else begin
          r_half <= r_half + HW'(1);
        end
      end
    end
  end

  assign w_gate = (r_sel == TONE_ERR) && (r_dur >= ERR_LO) && (r_dur < ERR_HI);
  assign buzzer = r_active & r_tone & ~w_gate;

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: key decode, BCD entry register, try counter, lockout timer
// and the ENTRY/PASS/LOCKOUT controller; tones come from buzzer_tone.
//   state      | meaning
//   ST_ENTRY   | collecting digits, ENTER compares against password
//   ST_PASS    | code accepted, waits for CLEAR or ADMIN
//   ST_LOCKOUT | too many failures, counts tick_1hz down to zero
module keypad_code_lock
  import lock_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int MAX_TRIES = 6,
  parameter int LOCKOUT_S = 30,
  parameter int KEY_DIV   = 50000,
  parameter int OK_DIV    = 25000,
  parameter int ERR_DIV   = 100000,
  parameter int KEY_CYC   = 10000000,
  parameter int OK_CYC    = 30000000,
  parameter int ERR_CYC   = 15000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           onehot,
  input  logic                  tick_1hz,
  input  logic [4*DIGITS-1:0]   password,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [3:0]            entered,
  output logic [3:0]            tries,
  output logic [1:0]            lock_state,
  output logic [7:0]            lock_secs,
  output logic                  buzzer
);

  localparam int EW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int SW = $clog2(LOCKOUT_S + 1);

  lock_state_e          r_state;
  lock_state_e          w_state_nxt;
  logic [15:0]          r_prev_key;
  logic [4*DIGITS-1:0]  r_digits;
  logic [EW-1:0]        r_entered;
  logic [TW-1:0]        r_tries;
  logic [SW-1:0]        r_secs;

  key_t       w_key;
  logic       w_event, w_digit, w_enter, w_clear, w_admin;
  logic       w_full, w_match, w_last_try, w_last_sec;
  logic       w_blank, w_shift, w_load_pass, w_load_lock;
  logic       w_try_inc, w_try_clr, w_secs_load, w_secs_dec, w_secs_clr;
  logic       w_req;
  logic [1:0] w_sel;

  assign w_key      = decode_key(onehot);
  assign w_event    = (onehot != r_prev_key) && w_key.valid;
  assign w_digit    = w_event && w_key.is_digit;
  assign w_enter    = w_event && w_key.enter;
  assign w_clear    = w_event && w_key.clear;
  assign w_admin    = w_event && w_key.admin;
  assign w_full     = (r_entered == EW'(DIGITS));
  assign w_match    = (r_digits == password);
  assign w_last_try = (r_tries == TW'(MAX_TRIES - 1));
  assign w_last_sec = (r_secs == SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ENTRY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ENTRY: begin
        if (!w_admin && w_enter && w_full) begin
          if (w_match)         w_state_nxt = ST_PASS;
          else if (w_last_try) w_state_nxt = ST_LOCKOUT;
        end
      end
      ST_PASS: begin
        if (w_clear || w_admin) w_state_nxt = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (w_admin || (tick_1hz && w_last_sec)) w_state_nxt = ST_ENTRY;
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  always_comb begin
    w_blank     = 1'b0;
    w_shift     = 1'b0;
    w_load_pass = 1'b0;
    w_load_lock = 1'b0;
    w_try_inc   = 1'b0;
    w_try_clr   = 1'b0;
    w_secs_load = 1'b0;
    w_secs_dec  = 1'b0;
    w_secs_clr  = 1'b0;
    w_req       = 1'b0;
    w_sel       = TONE_KEY;
    case (r_state)
      ST_ENTRY: begin
        if (w_admin) begin
          w_blank    = 1'b1;
          w_try_clr  = 1'b1;
          w_secs_clr = 1'b1;
          w_req      = 1'b1;
        end else if (w_clear) begin
          w_blank = 1'b1;
          w_req   = 1'b1;
        end else if (w_digit && !w_full) begin
          w_shift = 1'b1;
          w_req   = 1'b1;
        end else if (w_enter && w_full) begin
          w_req = 1'b1;
          if (w_match) begin
            w_load_pass = 1'b1;
            w_try_clr   = 1'b1;
            w_sel       = TONE_OK;
          end else begin
            w_try_inc = 1'b1;
            w_sel     = TONE_ERR;
            if (w_last_try) begin
              w_load_lock = 1'b1;
              w_secs_load = 1'b1;
            end else begin
              w_blank = 1'b1;
            end
          end
        end
      end
      ST_PASS: begin
        if (w_admin || w_clear) begin
          w_blank    = 1'b1;
          w_try_clr  = w_admin;
          w_secs_clr = w_admin;
          w_req      = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        // ADMIN wins over a tick landing in the same cycle; neither beeps here.
        if (w_admin) begin
          w_blank    = 1'b1;
          w_try_clr  = 1'b1;
          w_secs_clr = 1'b1;
        end else if (tick_1hz) begin
          w_secs_dec = 1'b1;
          if (w_last_sec) begin
            w_blank   = 1'b1;
            w_try_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_key <= '0;
      r_digits   <= {DIGITS{BLANK}};
      r_entered  <= '0;
      r_tries    <= '0;
      r_secs     <= '0;
    end else begin
      r_prev_key <= onehot;

      if (w_blank) begin
        r_digits  <= {DIGITS{BLANK}};
        r_entered <= '0;
      end else if (w_load_pass) begin
        r_digits <= {DIGITS{PASS_GLYPH}};
      end else if (w_load_lock) begin
        r_digits  <= {DIGITS{LOCK_GLYPH}};
        r_entered <= '0;
      end else if (w_shift) begin
        r_digits  <= (4*DIGITS)'({r_digits, w_key.digit});
        r_entered <= r_entered + EW'(1);
      end

      if (w_try_clr)
        r_tries <= '0;
      else if (w_try_inc && (r_tries < TW'(MAX_TRIES)))
        r_tries <= r_tries + TW'(1);

      if (w_secs_clr)       r_secs <= '0;
      else if (w_secs_load) r_secs <= SW'(LOCKOUT_S);
      else if (w_secs_dec)  r_secs <= r_secs - SW'(1);
    end
  end

  buzzer_tone #(
    .KEY_DIV (KEY_DIV),
    .OK_DIV  (OK_DIV),
    .ERR_DIV (ERR_DIV),
    .KEY_CYC (KEY_CYC),
    .OK_CYC  (OK_CYC),
    .ERR_CYC (ERR_CYC)
  ) u_buzzer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .sel    (w_sel),
    .buzzer (buzzer)
  );

  assign digits_out = r_digits;
  assign entered    = 4'(r_entered);
  assign tries      = 4'(r_tries);
  assign lock_state = r_state;
  assign lock_secs  = 8'(r_secs);

endmodule

// File: tb/tb_keypad_code_lock.sv
// Scoreboard bench for keypad_code_lock: a behavioural model queues expected
// outputs per stimulus cycle; a negedge monitor pops and compares them.
module tb_keypad_code_lock;

  localparam int DIGITS    = 3;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_S = 2;
  localparam int KEY_DIV   = 3;
  localparam int OK_DIV    = 2;
  localparam int ERR_DIV   = 5;
  localparam int KEY_CYC   = 24;
  localparam int OK_CYC    = 30;
  localparam int ERR_CYC   = 45;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] onehot = 16'h0;
  logic        tick_1hz = 1'b0;
  logic [11:0] password = 12'h0;
  logic [11:0] digits_out;
  logic [3:0]  entered;
  logic [3:0]  tries;
  logic [1:0]  lock_state;
  logic [7:0]  lock_secs;
  logic        buzzer;

  always #5 clk = ~clk;

  keypad_code_lock #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCKOUT_S(LOCKOUT_S),
    .KEY_DIV(KEY_DIV), .OK_DIV(OK_DIV), .ERR_DIV(ERR_DIV),
    .KEY_CYC(KEY_CYC), .OK_CYC(OK_CYC), .ERR_CYC(ERR_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .onehot(onehot), .tick_1hz(tick_1hz),
    .password(password), .digits_out(digits_out), .entered(entered),
    .tries(tries), .lock_state(lock_state), .lock_secs(lock_secs), .buzzer(buzzer)
  );

  typedef struct {
    int          due;
    logic [11:0] dig;
    int          ent;
    int          tr;
    int          st;
    int          secs;
    int          bz;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // index 0..9 digits, 10 ENTER, 11 CLEAR, 12 ADMIN
  logic [15:0] keymap [13] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                               16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000,
                               16'h0001, 16'h1000, 16'h0100};

  int          m_state, m_entry, m_cnt, m_tries, m_secs;
  logic [15:0] m_prev;
  int          t_kind, t_start;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
  endtask

  function automatic int key_index(input logic [15:0] k);
    for (int i = 0; i < 13; i++) if (keymap[i] == k) return i;
    return -1;
  endfunction

  function automatic logic [11:0] exp_digits();
    int v;
    if (m_state == 1) return 12'hAAA;
    if (m_state == 2) return 12'h000;
    v = ((32'hFFF << (4 * m_cnt)) | m_entry) & 32'hFFF;
    return v[11:0];
  endfunction

  // Expected buzzer level from elapsed time since the tone request took effect.
  function automatic int exp_buzzer(input int c);
    int n, len, div;
    if (t_kind < 0) return 0;
    n   = c - t_start;
    len = (t_kind == 0) ? KEY_CYC : (t_kind == 1) ? OK_CYC : ERR_CYC;
    div = (t_kind == 0) ? KEY_DIV : (t_kind == 1) ? OK_DIV : ERR_DIV;
    if (n < 0 || n >= len) return 0;
    if (t_kind == 2 && n >= len / 3 && n < (2 * len) / 3) return 0;
    return ((n / div) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_entry = 0; m_cnt = 0; m_tries = 0; m_secs = 0;
    m_prev = 16'h0; t_kind = -1; t_start = 0;
  endtask

  task automatic beep(input int kind);
    t_kind  = kind;
    t_start = cyc + 1;
  endtask

  task automatic clear_entry();
    m_entry = 0; m_cnt = 0;
  endtask

  task automatic model_eval(input logic [15:0] k, input logic t);
    int  kd;
    bit  ev;
    kd = key_index(k);
    ev = (k != m_prev) && (kd >= 0);
    m_prev = k;
    case (m_state)
      0: if (ev) begin
        if (kd == 12) begin clear_entry(); m_tries = 0; m_secs = 0; beep(0); end
        else if (kd == 11) begin clear_entry(); beep(0); end
        else if (kd < 10) begin
          if (m_cnt < DIGITS) begin m_entry = m_entry * 16 + kd; m_cnt++; beep(0); end
        end else if (m_cnt == DIGITS) begin
          if (m_entry == int'(password)) begin
            m_state = 1; m_tries = 0; beep(1);
          end else begin
            beep(2);
            clear_entry();
            if (m_tries + 1 == MAX_TRIES) begin m_state = 2; m_secs = LOCKOUT_S; end
            if (m_tries < MAX_TRIES) m_tries++;
          end
        end
      end
      1: if (ev && (kd == 11 || kd == 12)) begin
        m_state = 0; clear_entry(); beep(0);
        if (kd == 12) begin m_tries = 0; m_secs = 0; end
      end
      default: begin
        if (ev && kd == 12) begin
          m_state = 0; clear_entry(); m_tries = 0; m_secs = 0;
        end else if (t) begin
          m_secs--;
          if (m_secs == 0) begin m_state = 0; m_tries = 0; clear_entry(); end
        end
      end
    endcase
  endtask

  task automatic step(input logic [15:0] k, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    onehot   = k;
    tick_1hz = t;
    model_eval(k, t);
    e.due  = cyc + 1;
    e.dig  = exp_digits();
    e.ent  = m_cnt;
    e.tr   = m_tries;
    e.st   = m_state;
    e.secs = m_secs;
    e.bz   = exp_buzzer(cyc + 1);
    sbq.push_back(e);
  endtask

  task automatic press(input logic [15:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) step(k, 1'b0);
    for (int i = 0; i < gap; i++) step(16'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0, 1'b0);
  endtask

  task automatic enter_code(input logic [11:0] code);
    press(keymap[code[11:8]], 1, 1);
    press(keymap[code[7:4]], 1, 1);
    press(keymap[code[3:0]], 1, 1);
    press(keymap[10], 1, 1);
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    v[11:8] = 4'($urandom_range(0, 9));
    v[7:4]  = 4'($urandom_range(0, 9));
    v[3:0]  = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [15:0] rand_key();
    int          r;
    logic [15:0] unm [3] = '{16'h0002, 16'h0004, 16'h0010};
    r = $urandom_range(0, 15);
    if (r == 12 && $urandom_range(0, 3) != 0) r = $urandom_range(0, 9);
    if (r <= 12) return keymap[r];
    if (r == 13) return keymap[$urandom_range(0, 9)] | keymap[10];
    if (r == 14) return unm[$urandom_range(0, 2)];
    return 16'h0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("digits_out", int'(digits_out), int'(e.dig));
      chk("entered",    int'(entered),    e.ent);
      chk("tries",      int'(tries),      e.tr);
      chk("lock_state", int'(lock_state), e.st);
      chk("lock_secs",  int'(lock_secs),  e.secs);
      chk("buzzer",     int'(buzzer),     e.bz);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", int'(digits_out), 12'hFFF);
    chk("reset_entered", int'(entered), 0);
    chk("reset_tries", int'(tries), 0);
    chk("reset_state", int'(lock_state), 0);
    chk("reset_secs", int'(lock_secs), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    rst_n = 1'b1;

    // correct code, then CLEAR back to entry
    password = 12'h246;
    press(keymap[2], 1, 1);
    press(keymap[4], 1, 1);
    press(keymap[6], 1, 1);
    press(keymap[10], 1, 40);
    press(keymap[5], 1, 1);
    press(keymap[11], 1, 30);

    // overflow digit ignored, then wrong ENTER with full ERR pattern
    press(keymap[1], 1, 1);
    press(keymap[2], 1, 1);
    press(keymap[3], 1, 1);
    press(keymap[4], 1, 1);
    press(keymap[10], 1, 50);

    // reach lockout, keys ignored, two ticks release it
    enter_code(12'h123);
    enter_code(12'h999);
    press(keymap[1], 2, 2);
    press(keymap[10], 1, 1);
    press(keymap[11], 1, 3);
    step(16'h0, 1'b1);
    idle(3);
    step(16'h0, 1'b1);
    idle(30);

    // ADMIN coinciding with a tick in lockout
    enter_code(12'h111);
    enter_code(12'h222);
    enter_code(12'h333);
    idle(5);
    step(keymap[12], 1'b1);
    idle(30);

    // held key and multi-hot transition give a single digit
    press(16'h0040, 100, 0);
    press(16'h0041, 5, 30);
    press(keymap[11], 1, 30);

    // asynchronous reset in the middle of a tone
    enter_code(12'h777);
    press(keymap[5], 1, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("midtone_rst_buzzer", int'(buzzer), 0);
    chk("midtone_rst_digits", int'(digits_out), 12'hFFF);
    chk("midtone_rst_tries", int'(tries), 0);
    chk("midtone_rst_state", int'(lock_state), 0);
    chk("midtone_rst_entered", int'(entered), 0);
    model_reset();
    onehot = 16'h0;
    tick_1hz = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) == 0) password = rand_bcd();
      if ($urandom_range(0, 3) == 0) begin
        enter_code(($urandom_range(0, 1) == 0) ? password : rand_bcd());
      end else begin
        logic [15:0] k;
        int          hold, gap;
        k    = rand_key();
        hold = $urandom_range(1, 3);
        gap  = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) step(k, $urandom_range(0, 7) == 0);
        for (int i = 0; i < gap; i++) step(16'h0, $urandom_range(0, 7) == 0);
      end
    end
    idle(5);

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) chk("queue_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
